// File: rtl/boot_loader_ctrl_pkg.sv
// Header field positions, state encoding and write-strobe constants shared by the boot loader.
package boot_loader_ctrl_pkg;

  localparam int GO_BIT   = 31;
  localparam int TGT_BIT  = 30;
  localparam int ADDR_MSB = 23;
  localparam int ADDR_LSB = 12;
  localparam int CNT_MSB  = 10;
  localparam int CNT_LSB  = 0;

  localparam logic [3:0] BYTE_ALL  = 4'b1111;
  localparam logic [3:0] BYTE_NONE = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_LAST = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

endpackage

// File: rtl/boot_loader_ctrl.sv
// Loads header+payload segments into instruction/data BRAM and releases the core after a GO segment.
// Write lands one cycle after accept; s_ready drops in LAST/RUN so no stream word is consumed there.
module boot_loader_ctrl
  import boot_loader_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_dat,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  reload,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [3:0]            i_w_byte_enb,
  output logic [ADDR_WIDTH-1:0] d_w_addr,
  output logic [DATA_WIDTH-1:0] d_w_dat,
  output logic                  d_w_enb,
  output logic [3:0]            d_w_byte_enb,
  output logic                  i_r_enb,
  output logic                  pc_stall,
  output logic                  cpu_rst,
  output logic                  d_bram_init_done,
  output logic                  busy,
  output logic [15:0]           words_loaded
);

  state_t                state, next_state;
  logic                  rdy_en;
  logic                  hdr_acc, word_acc;
  logic                  tgt_q, go_q;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [CNT_WIDTH-1:0]  remaining;

  logic                  hdr_go, hdr_tgt;
  logic [ADDR_WIDTH-1:0] hdr_addr;
  logic [CNT_WIDTH-1:0]  hdr_cnt;
  logic                  in_run;
  logic                  unused_hdr_bits;

  assign hdr_go   = s_dat[GO_BIT];
  assign hdr_tgt  = s_dat[TGT_BIT];
  // Low two address bits of the field are dropped so every write is word aligned.
  assign hdr_addr = ADDR_WIDTH'({s_dat[ADDR_MSB:ADDR_LSB+2], 2'b00});
  assign hdr_cnt  = CNT_WIDTH'(s_dat[CNT_MSB:CNT_LSB]);
  assign unused_hdr_bits = ^{s_dat[29:24], s_dat[11], s_dat[ADDR_LSB+1:ADDR_LSB]};
  assign in_run   = (state == ST_RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      rdy_en <= 1'b0;
    end else begin
      state  <= next_state;
      rdy_en <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    s_ready    = 1'b0;
    hdr_acc    = 1'b0;
    word_acc   = 1'b0;
    case (state)
      ST_IDLE: begin
        s_ready = rdy_en;
        if (s_valid && rdy_en) begin
          hdr_acc = 1'b1;
          if (hdr_cnt != '0)  next_state = ST_DATA;
          else if (hdr_go)    next_state = ST_RUN;
        end
      end
      ST_DATA: begin
        s_ready = rdy_en;
        if (s_valid && rdy_en) begin
          word_acc = 1'b1;
          if (remaining == CNT_WIDTH'(1)) next_state = go_q ? ST_LAST : ST_IDLE;
        end
      end
      ST_LAST: next_state = ST_RUN;
      ST_RUN:  if (reload) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tgt_q            <= 1'b0;
      go_q             <= 1'b0;
      cur_addr         <= '0;
      remaining        <= '0;
      i_w_addr         <= '0;
      i_w_dat          <= '0;
      i_w_enb          <= 1'b0;
      i_w_byte_enb     <= BYTE_NONE;
      d_w_addr         <= '0;
      d_w_dat          <= '0;
      d_w_enb          <= 1'b0;
      d_w_byte_enb     <= BYTE_NONE;
      i_r_enb          <= 1'b0;
      pc_stall         <= 1'b1;
      cpu_rst          <= 1'b1;
      d_bram_init_done <= 1'b0;
      busy             <= 1'b1;
      words_loaded     <= '0;
    end else begin
      i_w_enb      <= 1'b0;
      i_w_byte_enb <= BYTE_NONE;
      d_w_enb      <= 1'b0;
      d_w_byte_enb <= BYTE_NONE;

      if (hdr_acc) begin
        tgt_q     <= hdr_tgt;
        go_q      <= hdr_go;
        cur_addr  <= hdr_addr;
        remaining <= hdr_cnt;
      end

      if (word_acc) begin
        if (tgt_q) begin
          d_w_addr     <= cur_addr;
          d_w_dat      <= s_dat;
          d_w_enb      <= 1'b1;
          d_w_byte_enb <= BYTE_ALL;
        end else begin
          i_w_addr     <= cur_addr;
          i_w_dat      <= s_dat;
          i_w_enb      <= 1'b1;
          i_w_byte_enb <= BYTE_ALL;
        end
        cur_addr  <= cur_addr + ADDR_WIDTH'(4);
        remaining <= remaining - CNT_WIDTH'(1);
        if (words_loaded != 16'hFFFF) words_loaded <= words_loaded + 16'd1;
      end

      // Run controls follow the registered state, so they move one edge after entering/leaving RUN.
      i_r_enb          <= in_run;
      pc_stall         <= !in_run;
      cpu_rst          <= !in_run;
      d_bram_init_done <= in_run;
      busy             <= !in_run;

      if (in_run && reload) words_loaded <= '0;
    end
  end

endmodule
